// File: rtl/fp64_pkg.sv
// Shared binary64 constants, field layout and operand classification.
// Used by every stage of the three-operand multiplier.
package fp64_pkg;

    localparam int          BIAS    = 1023;
    localparam int          EXP_MAX = 2047;
    localparam logic [63:0] FP_ONE  = 64'h3FF0000000000000;
    localparam logic [63:0] FP_QNAN = 64'h7FF8000000000000;

    typedef struct packed {
        logic        sign;
        logic [10:0] exp;
        logic [51:0] frac;
    } fp64_t;

    typedef enum logic [1:0] {
        FP_ZERO,
        FP_INF,
        FP_NAN,
        FP_NORM
    } fp_class_t;

    // Subnormals classify as zero: they are flushed before multiplying.
    function automatic fp_class_t fp_classify(input fp64_t v);
        if (v.exp == 11'd0)
            return FP_ZERO;
        if (v.exp == 11'h7FF)
            return (v.frac == '0) ? FP_INF : FP_NAN;
        return FP_NORM;
    endfunction

endpackage

// File: rtl/fp_mul3_pipe_if.sv
// Operand/result bundle of the three-operand multiplier.
// master drives operands, slave (the multiplier) drives the result.
interface fp_mul3_pipe_if;
    logic        pushin;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] c;
    logic        pushout;
    logic [63:0] r;

    modport master (output pushin, a, b, c, input pushout, r);
    modport slave  (input pushin, a, b, c, output pushout, r);
endinterface

// File: rtl/fp_mul2_stage.sv
// Two-operand binary64 multiplier, RNE, subnormals flushed to zero.
// Latency 4 cycles (unpack, two multiply stages, round/pack); no backpressure.
module fp_mul2_stage
    import fp64_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  fp64_t x,
    input  fp64_t y,
    output fp64_t z
);

    fp_class_t          cx, cy;
    logic               sgn;
    logic               spec;
    fp64_t              spec_val;

    logic               s1_sign, s2_sign, s3_sign;
    logic signed [12:0] s1_exp, s2_exp, s3_exp;
    logic        [52:0] s1_mx, s1_my;
    logic               s1_spec, s2_spec, s3_spec;
    fp64_t              s1_spec_val, s2_spec_val, s3_spec_val;
    logic        [79:0] s2_pp_lo;
    logic        [78:0] s2_pp_hi;
    logic       [105:0] s3_prod;

    logic        [52:0] mant;
    logic               guard, sticky, rnd;
    logic        [53:0] mant_r;
    logic signed [12:0] e_n, e_r;
    logic        [51:0] frac_r;
    fp64_t              res;

    assign cx  = fp_classify(x);
    assign cy  = fp_classify(y);
    assign sgn = x.sign ^ y.sign;

    always_comb begin
        spec     = 1'b1;
        spec_val = '{sign: sgn, exp: 11'd0, frac: 52'd0};
        if (cx == FP_NAN || cy == FP_NAN ||
            (cx == FP_ZERO && cy == FP_INF) || (cx == FP_INF && cy == FP_ZERO))
            spec_val = FP_QNAN;
        else if (cx == FP_INF || cy == FP_INF)
            spec_val = '{sign: sgn, exp: 11'(EXP_MAX), frac: 52'd0};
        else if (cx == FP_ZERO || cy == FP_ZERO)
            spec_val = '{sign: sgn, exp: 11'd0, frac: 52'd0};
        else
            spec = 1'b0;
    end

    // Product of two [1,2) significands lies in [1,4): at most one right shift.
    always_comb begin
        if (s3_prod[105]) begin
            mant   = s3_prod[105:53];
            guard  = s3_prod[52];
            sticky = |s3_prod[51:0];
            e_n    = s3_exp + 13'sd1;
        end else begin
            mant   = s3_prod[104:52];
            guard  = s3_prod[51];
            sticky = |s3_prod[50:0];
            e_n    = s3_exp;
        end
        rnd    = guard & (sticky | mant[0]);
        mant_r = {1'b0, mant} + {53'd0, rnd};
        e_r    = mant_r[53] ? e_n + 13'sd1 : e_n;
        frac_r = mant_r[53] ? mant_r[52:1] : mant_r[51:0];

        if (s3_spec)
            res = s3_spec_val;
        else if (int'(e_r) >= EXP_MAX)
            res = '{sign: s3_sign, exp: 11'(EXP_MAX), frac: 52'd0};
        else if (int'(e_r) <= 0)
            res = '{sign: s3_sign, exp: 11'd0, frac: 52'd0};
        else
            res = '{sign: s3_sign, exp: e_r[10:0], frac: frac_r};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_sign <= 1'b0;  s1_exp <= '0;  s1_mx <= '0;  s1_my <= '0;
            s1_spec <= 1'b0;  s1_spec_val <= '0;
            s2_sign <= 1'b0;  s2_exp <= '0;  s2_pp_lo <= '0;  s2_pp_hi <= '0;
            s2_spec <= 1'b0;  s2_spec_val <= '0;
            s3_sign <= 1'b0;  s3_exp <= '0;  s3_prod <= '0;
            s3_spec <= 1'b0;  s3_spec_val <= '0;
            z       <= '0;
        end else begin
            s1_sign     <= sgn;
            s1_exp      <= 13'(int'(x.exp) + int'(y.exp) - BIAS);
            s1_mx       <= {1'b1, x.frac};
            s1_my       <= {1'b1, y.frac};
            s1_spec     <= spec;
            s1_spec_val <= spec_val;

            s2_sign     <= s1_sign;
            s2_exp      <= s1_exp;
            s2_pp_lo    <= {27'd0, s1_mx} * {53'd0, s1_my[26:0]};
            s2_pp_hi    <= {26'd0, s1_mx} * {53'd0, s1_my[52:27]};
            s2_spec     <= s1_spec;
            s2_spec_val <= s1_spec_val;

            s3_sign     <= s2_sign;
            s3_exp      <= s2_exp;
            s3_prod     <= {26'd0, s2_pp_lo} + {s2_pp_hi, 27'd0};
            s3_spec     <= s2_spec;
            s3_spec_val <= s2_spec_val;

            z           <= res;
        end
    end

endmodule

// File: rtl/fp_mul3_pipe.sv
// Three-operand binary64 multiplier r = round(round(a*b)*c).
// Latency 9 cycles, one op per cycle; no backpressure or stall.
module fp_mul3_pipe
    import fp64_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    fp_mul3_pipe_if.slave   io
);

    fp64_t       p, q;
    logic [63:0] c_dly [4];
    logic [8:0]  vld;
    logic [63:0] r_q;

    fp_mul2_stage u_mul_ab (
        .clk (clk),
        .rst (rst),
        .x   (io.a),
        .y   (io.b),
        .z   (p)
    );

    fp_mul2_stage u_mul_pc (
        .clk (clk),
        .rst (rst),
        .x   (p),
        .y   (c_dly[3]),
        .z   (q)
    );

    // c waits out the first multiplier so it meets p at the second one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++)
                c_dly[i] <= '0;
            vld <= '0;
            r_q <= '0;
        end else begin
            c_dly[0] <= io.c;
            for (int i = 1; i < 4; i++)
                c_dly[i] <= c_dly[i-1];
            vld <= {vld[7:0], io.pushin};
            r_q <= q;
        end
    end

    assign io.pushout = vld[8];
    assign io.r       = r_q;

endmodule

// File: tb/tb_fp_mul3_pipe.sv
module tb_fp_mul3_pipe;
    import fp64_pkg::*;

    typedef struct {
        logic [63:0] r;
        int          t;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   out_cnt = 0;
    exp_t sb[$];

    fp_mul3_pipe_if io();

    fp_mul3_pipe dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference: IEEE double multiply of the host, then the flush/NaN rules.
    function automatic logic [63:0] ref_mul(input logic [63:0] fa, input logic [63:0] fb);
        logic [63:0] x, y, p;
        x = (fa[62:52] == 11'd0) ? {fa[63], 63'd0} : fa;
        y = (fb[62:52] == 11'd0) ? {fb[63], 63'd0} : fb;
        p = $realtobits($bitstoreal(x) * $bitstoreal(y));
        if (p[62:52] == 11'h7FF && p[51:0] != 52'd0)
            return FP_QNAN;
        if (p[62:52] == 11'd0)
            return {p[63], 63'd0};
        return p;
    endfunction

    function automatic logic [63:0] rand_fp();
        logic [63:0] t;
        logic [51:0] f;
        logic        s;
        t = {$urandom, $urandom};
        f = t[51:0];
        s = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 15))
            0:       return {s, 63'd0};
            1:       return {s, 11'h7FF, 52'd0};
            2:       return {s, 11'h7FF, f | 52'd1};
            3:       return {s, 11'd0, f};
            4:       return {s, 11'($urandom_range(1, 2046)), f};
            default: return {s, 11'($urandom_range(923, 1123)), f};
        endcase
    endfunction

    task automatic issue(input logic [63:0] ta, input logic [63:0] tb_, input logic [63:0] tc,
                         input logic [63:0] te);
        @(posedge clk); #1;
        io.pushin = 1'b1;
        io.a = ta;
        io.b = tb_;
        io.c = tc;
        sb.push_back('{te, cyc});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            io.pushin = 1'b0;
            io.a = {$urandom, $urandom};
            io.b = {$urandom, $urandom};
            io.c = {$urandom, $urandom};
        end
    endtask

    // Monitor: every pushout must match the oldest outstanding op, 9 cycles on.
    always @(negedge clk) begin
        if (io.pushout) begin
            out_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pushout: r=%h with no op outstanding", io.r);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", io.r, e.r);
                chk("latency", 64'(cyc - e.t), 64'd9);
            end
        end
    end

    initial begin
        logic [63:0] ra, rb, rc;
        int base;
        io.pushin = 1'b0;
        io.a = '0;
        io.b = '0;
        io.c = '0;

        repeat (2) @(negedge clk);
        chk("reset_pushout", 64'(io.pushout), 64'd0);
        chk("reset_r", io.r, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        idle(2);

        issue(FP_ONE, FP_ONE, FP_ONE, FP_ONE);
        idle(12);
        issue(64'hBFF8000000000000, 64'h4000000000000000, 64'h3FE0000000000000, 64'hBFF8000000000000);
        issue(64'h3FF0000000000001, 64'h3FF0000000000001, FP_ONE, 64'h3FF0000000000002);
        issue(64'h0000000000000000, 64'h7FF0000000000000, FP_ONE, FP_QNAN);
        issue(64'h7FEFFFFFFFFFFFFF, 64'h4000000000000000, FP_ONE, 64'h7FF0000000000000);
        issue(64'h0000000000000001, FP_ONE, FP_ONE, 64'h0000000000000000);
        idle(3);

        for (int k = 1; k <= 20; k++)
            issue($realtobits(real'(k)), 64'h4000000000000000, FP_ONE, $realtobits(2.0 * k));
        idle(12);

        for (int i = 0; i < 300; i++) begin
            ra = rand_fp();
            rb = rand_fp();
            rc = ($urandom_range(0, 1) == 0) ? FP_ONE : rand_fp();
            issue(ra, rb, rc, ref_mul(ref_mul(ra, rb), rc));
            if ($urandom_range(0, 3) == 0)
                idle($urandom_range(1, 3));
        end
        idle(12);

        // Reset during a burst: in-flight ops must vanish.
        for (int i = 0; i < 4; i++)
            issue(rand_fp(), rand_fp(), FP_ONE, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        io.pushin = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("inreset_pushout", 64'(io.pushout), 64'd0);
        chk("inreset_r", io.r, 64'd0);
        @(negedge clk);
        chk("inreset_r_hold", io.r, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        base = out_cnt;
        idle(15);
        chk("post_reset_quiet", 64'(out_cnt - base), 64'd0);

        for (int k = 1; k <= 3; k++)
            issue($realtobits(real'(k)), 64'hC000000000000000, FP_ONE, $realtobits(-2.0 * k));
        idle(1);

        for (int i = 0; i < 50 && sb.size() != 0; i++)
            @(negedge clk);
        chk("drain_outstanding", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
